// File: rtl/uart_pkg.sv
// Shared UART clocking definitions: default clock/oversample rates, the
// standard baud constants, rate-select encoding and the half-period formula.
package uart_pkg;

    localparam int unsigned CLK_FREQ_DEFAULT   = 50_000_000;
    localparam int unsigned OVERSAMPLE_DEFAULT = 16;

    localparam int unsigned BAUD0_DEFAULT = 2400;
    localparam int unsigned BAUD1_DEFAULT = 4800;
    localparam int unsigned BAUD2_DEFAULT = 9600;
    localparam int unsigned BAUD3_DEFAULT = 19200;

    typedef enum logic [1:0] {
        BAUD_2400  = 2'b00,
        BAUD_4800  = 2'b01,
        BAUD_9600  = 2'b10,
        BAUD_19200 = 2'b11
    } baud_sel_t;

    // Clocks per half period of the oversampling clock, rounded down after
    // adding half a full period's worth of bias.
    function automatic int unsigned half_count(input int unsigned clk,
                                               input int unsigned baud,
                                               input int unsigned os);
        return (clk + baud * os) / (2 * baud * os);
    endfunction

endpackage

// File: rtl/baud_div_counter.sv
// Generic half-period counter with toggle flop; the parent supplies the
// terminal-count compare and any restart (clear) condition.
module baud_div_counter #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             enable,
    input  logic             terminal,
    output logic [CNT_W-1:0] count,
    output logic             clk_out
);

    // clear restarts the half period without touching the output level
    always_ff @(posedge clock) begin
        if (reset) begin
            count   <= '0;
            clk_out <= 1'b0;
        end else if (clear) begin
            count   <= '0;
        end else if (enable) begin
            if (terminal) begin
                count   <= '0;
                clk_out <= ~clk_out;
            end else begin
                count   <= count + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/baud_gen_r.sv
// Receive-side baud generator: 50 % duty clock at OVERSAMPLE x the baud
// rate picked by baud_rate, restarting the half period on any rate change.
module baud_gen_r
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ   = CLK_FREQ_DEFAULT,
    parameter int unsigned OVERSAMPLE = OVERSAMPLE_DEFAULT,
    parameter int unsigned BAUD0      = BAUD0_DEFAULT,
    parameter int unsigned BAUD1      = BAUD1_DEFAULT,
    parameter int unsigned BAUD2      = BAUD2_DEFAULT,
    parameter int unsigned BAUD3      = BAUD3_DEFAULT,
    parameter int unsigned CNT_W      = 16
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic [1:0] baud_rate,
    output logic       baud_clk
);

    localparam logic [CNT_W-1:0] HALF0 = CNT_W'(half_count(CLK_FREQ, BAUD0, OVERSAMPLE));
    localparam logic [CNT_W-1:0] HALF1 = CNT_W'(half_count(CLK_FREQ, BAUD1, OVERSAMPLE));
    localparam logic [CNT_W-1:0] HALF2 = CNT_W'(half_count(CLK_FREQ, BAUD2, OVERSAMPLE));
    localparam logic [CNT_W-1:0] HALF3 = CNT_W'(half_count(CLK_FREQ, BAUD3, OVERSAMPLE));

    baud_sel_t        sel_q;
    logic [CNT_W-1:0] half_sel;
    logic [CNT_W-1:0] count;
    logic             rate_change;
    logic             terminal;

    // The copy follows the input every edge, which matches loading it only
    // on reset or on a detected mismatch.
    always_ff @(posedge clock) begin
        sel_q <= baud_sel_t'(baud_rate);
    end

    always_comb begin
        half_sel = HALF0;
        case (sel_q)
            BAUD_2400:  half_sel = HALF0;
            BAUD_4800:  half_sel = HALF1;
            BAUD_9600:  half_sel = HALF2;
            BAUD_19200: half_sel = HALF3;
            default:    half_sel = HALF0;
        endcase
    end

    assign rate_change = (baud_sel_t'(baud_rate) != sel_q);
    assign terminal    = (count == half_sel - CNT_W'(1));

    baud_div_counter #(
        .CNT_W (CNT_W)
    ) u_div (
        .clock    (clock),
        .reset    (reset_n),
        .clear    (rate_change),
        .enable   (1'b1),
        .terminal (terminal),
        .count    (count),
        .clk_out  (baud_clk)
    );

endmodule

// File: tb/tb_baud_gen_r.sv
// Self-checking bench for baud_gen_r: deadline-based reference model checked
// every cycle, plus table-driven half-period measurements and corner cases.
module tb_baud_gen_r;

    logic       clock;
    logic       reset_n;
    logic [1:0] baud_rate;
    logic       baud_clk;

    int unsigned tests;
    int unsigned fails;

    baud_gen_r dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .baud_rate (baud_rate),
        .baud_clk  (baud_clk)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference: each rate's half period from the rounding rule.
    function automatic int ref_half(input logic [1:0] r);
        int baud;
        case (r)
            2'b00:   baud = 2400;
            2'b01:   baud = 4800;
            2'b10:   baud = 9600;
            default: baud = 19200;
        endcase
        return (50_000_000 + baud * 16) / (2 * baud * 16);
    endfunction

    // Model state: absolute edge number of the next expected toggle.
    longint     cyc;
    longint     deadline;
    logic       m_level;
    logic [1:0] m_sel;

    task automatic check(input string name, input longint act, input longint exp);
        tests++;
        if (act != exp) begin
            fails++;
            if (fails <= 40)
                $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step(input logic rst, input logic [1:0] rate);
        reset_n   = rst;
        baud_rate = rate;
        @(posedge clock);
        cyc++;
        if (rst) begin
            m_level  = 1'b0;
            m_sel    = rate;
            deadline = cyc + ref_half(rate);
        end else if (rate != m_sel) begin
            m_sel    = rate;
            deadline = cyc + ref_half(rate);
        end else if (cyc == deadline) begin
            m_level  = ~m_level;
            deadline = cyc + ref_half(m_sel);
        end
        #1;
        check("model", baud_clk, m_level);
    endtask

    task automatic wait_toggle(input logic [1:0] rate, output int n);
        logic start;
        start = baud_clk;
        n = 0;
        do begin
            step(1'b0, rate);
            n++;
        end while (baud_clk == start && n < 5000);
        if (baud_clk == start) check("toggle_timeout", n, -1);
    endtask

    typedef struct {
        logic [1:0] rate;
        int         exp_half;
    } vec_t;

    vec_t vecs[4];
    int   n;

    initial begin
        tests = 0; fails = 0; cyc = 0; deadline = -1; m_level = 1'b0; m_sel = 2'b00;
        reset_n = 1'b1; baud_rate = 2'b00;

        vecs[0] = '{2'b01, 326};
        vecs[1] = '{2'b00, 651};
        vecs[2] = '{2'b10, 163};
        vecs[3] = '{2'b11, 81};

        // Reset for 5 clocks, then first rise at 651 and fall at 1302
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 2'b00);
            check("reset_low", baud_clk, 0);
        end
        wait_toggle(2'b00, n);
        check("first_rise", n, 651);
        check("first_rise_level", baud_clk, 1);
        wait_toggle(2'b00, n);
        check("first_fall", n, 651);
        check("first_fall_level", baud_clk, 0);

        // Rate sweep: latency from reset and three full periods per rate
        foreach (vecs[v]) begin
            for (int i = 0; i < 3; i++) step(1'b1, vecs[v].rate);
            wait_toggle(vecs[v].rate, n);
            check("sweep_latency", n, vecs[v].exp_half);
            for (int p = 0; p < 6; p++) begin
                wait_toggle(vecs[v].rate, n);
                check("sweep_half", n, vecs[v].exp_half);
            end
        end

        // 00 -> 11 with the counter near 500: level holds, toggle 81 later
        for (int i = 0; i < 2; i++) step(1'b1, 2'b00);
        wait_toggle(2'b00, n);
        check("pre_switch_rise", n, 651);
        for (int i = 0; i < 500; i++) step(1'b0, 2'b00);
        step(1'b0, 2'b11);
        check("switch_hold", baud_clk, 1);
        wait_toggle(2'b11, n);
        check("switch_fast", n, 81);
        wait_toggle(2'b11, n);
        check("fast_steady", n, 81);

        // 11 -> 00 mid-phase: next toggle 651 after the change edge
        for (int i = 0; i < 40; i++) step(1'b0, 2'b11);
        step(1'b0, 2'b00);
        check("switch_slow_hold", baud_clk, 1);
        wait_toggle(2'b00, n);
        check("switch_slow", n, 651);

        // Reset while high, then restart at rate 10
        if (baud_clk != 1'b1) wait_toggle(2'b00, n);
        check("pre_reset_high", baud_clk, 1);
        step(1'b1, 2'b10);
        check("reset_mid", baud_clk, 0);
        step(1'b1, 2'b10);
        wait_toggle(2'b10, n);
        check("post_reset_rise", n, 163);

        // Random rate changes and occasional resets against the model
        for (int i = 0; i < 20000; i++) begin
            logic [1:0] r;
            logic       rs;
            r  = ($urandom_range(0, 299) == 0) ? 2'($urandom_range(0, 3)) : baud_rate;
            rs = ($urandom_range(0, 4999) == 0);
            step(rs, r);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/baud_gen_r.md
Name: baud_gen_r

Overview:
- Receive-side baud-rate generator for the UART block.
- Divides the 50 MHz system clock into a 50 %-duty sampling clock at 16x the selected baud rate, for the UART receiver's oversampling logic.
- The rate is selected at run time by a 2-bit code.

Parameters:
- CLK_FREQ, 50_000_000, system clock frequency in Hz.
- OVERSAMPLE, 16, receiver oversampling factor.
- BAUD0, 2400, baud rate for baud_rate=2'b00.
- BAUD1, 4800, baud rate for baud_rate=2'b01.
- BAUD2, 9600, baud rate for baud_rate=2'b10.
- BAUD3, 19200, baud rate for baud_rate=2'b11.
- CNT_W, 16, half-period counter width; must hold the largest half-period count.

Ports:
- clock  in  1  system clock; all logic on its rising edge.
- reset_n  in  1  synchronous, active-high reset. The port name is kept for codebase consistency; a 1 resets.
- baud_rate  in  2  rate select: 00=BAUD0, 01=BAUD1, 10=BAUD2, 11=BAUD3.
- baud_clk  out  1  16x-oversampling clock, 50 % duty, registered output.

Behaviour:
- Half-period count for each rate: HALF_n = (CLK_FREQ + BAUDn*OVERSAMPLE) / (2*BAUDn*OVERSAMPLE), integer division, computed at elaboration.
- Defaults: HALF0=651, HALF1=326, HALF2=163, HALF3=81 clocks.
- Full baud_clk period is 2*HALF_n clocks: 1302 / 652 / 326 / 162.
- Reset, sampled on a clock edge while reset_n=1: counter<=0, baud_clk<=0, registered select copy<=baud_rate. Reset dominates all other events.
- Normal operation: counter increments by 1 each clock.
- When counter == HALF_sel-1: counter<=0 and baud_clk<=~baud_clk in the same edge.
- The first baud_clk rising edge occurs HALF_sel clocks after the first non-reset edge. Example: rate 00 gives high at edge 651, low at edge 1302.
- Rate change: baud_rate is compared with its registered copy each clock. On mismatch, counter<=0, copy<=baud_rate, and baud_clk holds its level.
- The new rate's first toggle occurs HALF_new clocks after the change edge. No glitch or short pulse is allowed; a half-period is never shorter than the smaller of the old and new HALF values.
- Counter is never allowed to exceed HALF_sel-1. The rate-change clear guarantees this when switching from a slow to a fast rate.
- baud_clk is driven only from a flop, never combinationally.
- Latency from reset release to first edge is exactly HALF_sel clocks. No other outputs exist.

Decomposition:
- Shared package uart_pkg holds:
  - CLK_FREQ_DEFAULT, OVERSAMPLE_DEFAULT;
  - the four BAUD constants;
  - a 2-bit baud_sel_t enum: BAUD_2400, BAUD_4800, BAUD_9600, BAUD_19200;
  - a constant function half_count(clk, baud, os) implementing the rounding formula.
- Package is shared with the transmit-side generator.
- Optional sub-module: baud_div_counter. It is a generic half-period counter and toggle flop with inputs terminal, clear, and enable. The top level adds the select mux and change detection. It is reusable by the TX generator.

Test Plan:
- Reset held 5 clocks with baud_rate=00 -> baud_clk=0 throughout, counter=0. After release, baud_clk rises at edge 651 and falls at edge 1302.
- Steady rate 01 for 3 full periods -> every baud_clk high and low phase lasts exactly 326 clocks; period is 652.
- Sweep rates 00, 01, 10, 11, measuring each half-period -> 651, 326, 163, 81 clocks respectively.
- Switch 00 to 11 mid-half-period, with counter at about 500 -> baud_clk holds its level, then toggles exactly 81 clocks after the change edge. No runt pulse.
- Switch 11 to 00 -> next toggle exactly 651 clocks after the change.
- Assert reset_n=1 mid-operation while baud_clk=1 -> baud_clk=0 on the next edge. After release, the first rise is HALF_sel clocks later.
